cgra_lsu_arbiter: RTL and testbench
===================================

CGRA_LSU_ARBITER -- requirements
Module: cgra_lsu_arbiter

Interface
REQ-001 SHALL have parameter NB_TILES, default 16: number of tile requesters.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: read-response watchdog limit (8-bit).
REQ-003 SHALL have port Clk  in  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Tile_Req_I  in  NB_TILES  per-tile load/store request, level, held until granted.
REQ-006 SHALL have port Tile_Load_I  in  NB_TILES  per-tile direction: 1 load, 0 store.
REQ-007 SHALL have port Tile_Addr_I  in  NB_TILES*32  per-tile byte address; tile i occupies bits [32i+31:32i].
REQ-008 SHALL have port Tile_Wdata_I  in  NB_TILES*32  per-tile store data, same packing.
REQ-009 SHALL have port Tile_Grant_O  in/out: out  NB_TILES  one-cycle completion pulse to owner tile.
REQ-010 SHALL have port Tile_Rvalid_O  out  NB_TILES  one-cycle load-data-valid pulse to owner tile.
REQ-011 SHALL have port Tile_Rdata_O  out  32  load data, broadcast to all tiles.
REQ-012 SHALL have port Stall_O  out  NB_TILES  per-tile stall indication.
REQ-013 SHALL have ports Mem_Req_O out 1, Mem_We_O out 1, Mem_Addr_O out 32, Mem_Wdata_O out 32: memory request side.
REQ-014 SHALL have ports Mem_Gnt_I in 1, Mem_Rvalid_I in 1, Mem_Rdata_I in 32: memory response side.
REQ-015 SHALL have port Err_O  out  1  sticky watchdog-timeout flag.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT_R, RESP.
REQ-017 IDLE: if any Tile_Req_I bit set, SHALL latch owner index, direction, address, wdata from the round-robin winner and go to REQ next cycle; otherwise stay.
REQ-018 Round-robin: search SHALL start at (last owner + 1) mod NB_TILES, wrapping from NB_TILES-1 to 0; after reset search starts at tile 0.
REQ-019 REQ: Mem_Req_O=1, Mem_We_O=!load, Mem_Addr_O/Mem_Wdata_O = latched values, all stable until Mem_Gnt_I=1.
REQ-020 REQ with Mem_Gnt_I=1: store -> RESP; load -> WAIT_R.
REQ-021 WAIT_R: Mem_Req_O=0; on Mem_Rvalid_I=1 SHALL capture Mem_Rdata_I and go to RESP.
REQ-022 Mem_Rvalid_I in the same cycle as Mem_Gnt_I SHALL be ignored; response is accepted only in WAIT_R.
REQ-023 RESP (exactly one cycle): Tile_Grant_O[owner]=1; for loads also Tile_Rvalid_O[owner]=1 and Tile_Rdata_O = captured data; then IDLE.
REQ-024 Tile_Rdata_O SHALL hold last captured load data outside RESP.
REQ-025 Stall_O[i] SHALL equal Tile_Req_I[i] AND NOT (state==RESP AND owner==i).
REQ-026 Minimum latency store: request seen in IDLE -> grant 3 cycles later with Mem_Gnt_I=1 on first REQ cycle; load: 4 cycles with Rvalid one cycle after Gnt.
REQ-027 Request inputs SHALL be sampled only in IDLE; changes in other states SHALL NOT affect the transaction in flight.
REQ-028 At most one Tile_Grant_O bit and one Tile_Rvalid_O bit SHALL be high in any cycle.

Reset
REQ-029 Reset low SHALL immediately force IDLE, round-robin pointer to NB_TILES-1, all outputs 0, Err_O 0, captured data 0, including mid-transaction.

Configuration
REQ-030 Macro CGRA_LSU_TIMEOUT_EN defined: an 8-bit counter SHALL clear on WAIT_R entry, increment each WAIT_R cycle; on reaching TIMEOUT_CYCLES without Mem_Rvalid_I, FSM SHALL go to RESP with data 32'hDEADBEEF and set Err_O until reset.
REQ-031 Macro undefined: no counter; WAIT_R waits indefinitely; Err_O tied 0.

Verification
REQ-032 Single store tile 3, addr 0x100, wdata 0xA5A5A5A5, Gnt on first REQ cycle -> Mem_We_O=1, Mem_Addr_O=0x100, Tile_Grant_O=0x0008 for one cycle, Rvalid 0.
REQ-033 Load tile 0, Gnt delayed 2 cycles, Rvalid+Rdata 0x12345678 one cycle later -> Mem_Req_O held 3 cycles, Tile_Rvalid_O[0] and Tile_Grant_O[0] pulse with Tile_Rdata_O=0x12345678.
REQ-034 All 16 tiles requesting continuously -> grants in order 0,1,...,15,0; no tile granted twice before all others.
REQ-035 Reset low during WAIT_R -> all outputs 0 same cycle; after release, tile 0 wins first arbitration.
REQ-036 With CGRA_LSU_TIMEOUT_EN, load with no Rvalid -> after 255 WAIT_R cycles RESP with Tile_Rdata_O=0xDEADBEEF, Err_O=1 sticky; without macro FSM remains in WAIT_R.

Source files
------------

// File: rtl/cgra_lsu_arbiter.sv
// cgra_lsu_arbiter
//   Round-robin arbiter that funnels NB_TILES tile load/store requests onto a
//   single memory port. One transaction is in flight at a time:
//   IDLE -> REQ -> (WAIT_R for loads) -> RESP -> IDLE.
//
//   Optional build macro: CGRA_LSU_TIMEOUT_EN
//     defined   : 8-bit read-response watchdog; after TIMEOUT_CYCLES WAIT_R
//                 cycles without Mem_Rvalid_I the load completes with
//                 32'hDEADBEEF and the sticky Err_O flag is raised.
//     undefined : WAIT_R waits indefinitely; Err_O is tied low.
//
// Ports
//   Clk, Reset         clock (rising edge), asynchronous active-low reset
//   Tile_Req_I         per-tile request level, held until granted
//   Tile_Load_I        per-tile direction (1 load, 0 store)
//   Tile_Addr_I        per-tile byte address, tile i at [32i+31:32i]
//   Tile_Wdata_I       per-tile store data, same packing
//   Tile_Grant_O       one-cycle completion pulse to the owner tile
//   Tile_Rvalid_O      one-cycle load-data-valid pulse to the owner tile
//   Tile_Rdata_O       last captured load data, broadcast
//   Stall_O            per-tile stall (requesting and not completing now)
//   Mem_Req_O/We/Addr/Wdata   memory request side
//   Mem_Gnt_I/Rvalid_I/Rdata_I memory response side
//   Err_O              sticky watchdog-timeout flag
module cgra_lsu_arbiter #(
  parameter int unsigned NB_TILES       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NB_TILES-1:0]      Tile_Req_I,
  input  logic [NB_TILES-1:0]      Tile_Load_I,
  input  logic [NB_TILES*32-1:0]   Tile_Addr_I,
  input  logic [NB_TILES*32-1:0]   Tile_Wdata_I,
  output logic [NB_TILES-1:0]      Tile_Grant_O,
  output logic [NB_TILES-1:0]      Tile_Rvalid_O,
  output logic [31:0]              Tile_Rdata_O,
  output logic [NB_TILES-1:0]      Stall_O,
  output logic                     Mem_Req_O,
  output logic                     Mem_We_O,
  output logic [31:0]              Mem_Addr_O,
  output logic [31:0]              Mem_Wdata_O,
  input  logic                     Mem_Gnt_I,
  input  logic                     Mem_Rvalid_I,
  input  logic [31:0]              Mem_Rdata_I,
  output logic                     Err_O
);

  localparam int unsigned OW = (NB_TILES > 1) ? $clog2(NB_TILES) : 1;

  // The watchdog counter is 8 bits wide; reject limits it cannot reach.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("cgra_lsu_arbiter: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  // r_owner doubles as the round-robin pointer: the next search starts one
  // past it. Resetting it to NB_TILES-1 makes tile 0 the first candidate.
  logic [OW-1:0] r_owner;
  logic          r_load;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;

  logic [OW-1:0] w_win;
  logic          w_any;
  int unsigned   w_idx;
  logic          w_timeout;

  // Round-robin winner search starting at (r_owner + 1) mod NB_TILES.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = 0;
    for (int unsigned k = 0; k < NB_TILES; k++) begin
      w_idx = 32'(r_owner) + k + 1;
      if (w_idx >= NB_TILES) w_idx = w_idx - NB_TILES;
      if (!w_any && Tile_Req_I[w_idx[OW-1:0]]) begin
        w_any = 1'b1;
        w_win = w_idx[OW-1:0];
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    Mem_Req_O     = 1'b0;
    Mem_We_O      = 1'b0;
    Tile_Grant_O  = '0;
    Tile_Rvalid_O = '0;
    case (r_state)
      IDLE: begin
        if (w_any) w_next = REQ;
      end
      REQ: begin
        Mem_Req_O = 1'b1;
        Mem_We_O  = !r_load;
        if (Mem_Gnt_I) w_next = r_load ? WAIT_R : RESP;
      end
      WAIT_R: begin
        if (Mem_Rvalid_I || w_timeout) w_next = RESP;
      end
      RESP: begin
        Tile_Grant_O[r_owner]  = 1'b1;
        Tile_Rvalid_O[r_owner] = r_load;
        w_next                 = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_owner <= OW'(NB_TILES - 1);
      r_load  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_win;
        r_load  <= Tile_Load_I[w_win];
        r_addr  <= Tile_Addr_I[32*w_win +: 32];
        r_wdata <= Tile_Wdata_I[32*w_win +: 32];
      end
      // Read data is only accepted in WAIT_R, so an Rvalid that coincides
      // with the grant cycle is dropped.
      if (r_state == WAIT_R) begin
        if (Mem_Rvalid_I)   r_rdata <= Mem_Rdata_I;
        else if (w_timeout) r_rdata <= 32'hDEADBEEF;
      end
    end
  end

`ifdef CGRA_LSU_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_err;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == REQ && Mem_Gnt_I && r_load) r_cnt <= '0;
      else if (r_state == WAIT_R)                r_cnt <= r_cnt + 8'd1;
      if (r_state == WAIT_R && !Mem_Rvalid_I && w_timeout) r_err <= 1'b1;
    end
  end

  // r_cnt holds the number of completed WAIT_R cycles, so the limit fires
  // during the TIMEOUT_CYCLES-th cycle.
  assign w_timeout = (r_state == WAIT_R) && (r_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign Err_O     = r_err;
`else
  assign w_timeout = 1'b0;
  assign Err_O     = 1'b0;
`endif

  assign Mem_Addr_O   = r_addr;
  assign Mem_Wdata_O  = r_wdata;
  assign Tile_Rdata_O = r_rdata;
  // Tile_Grant_O is exactly the (RESP && owner) one-hot. Stall is also forced
  // low while Reset is asserted so every output reads zero during reset.
  assign Stall_O      = Reset ? (Tile_Req_I & ~Tile_Grant_O) : '0;

endmodule

// File: tb/tb_cgra_lsu_arbiter.sv
module tb_cgra_lsu_arbiter;

  localparam int N = 16;

  logic            Clk = 1'b0;
  logic            Reset;
  logic [N-1:0]    Tile_Req_I;
  logic [N-1:0]    Tile_Load_I;
  logic [N*32-1:0] Tile_Addr_I;
  logic [N*32-1:0] Tile_Wdata_I;
  logic [N-1:0]    Tile_Grant_O;
  logic [N-1:0]    Tile_Rvalid_O;
  logic [31:0]     Tile_Rdata_O;
  logic [N-1:0]    Stall_O;
  logic            Mem_Req_O;
  logic            Mem_We_O;
  logic [31:0]     Mem_Addr_O;
  logic [31:0]     Mem_Wdata_O;
  logic            Mem_Gnt_I;
  logic            Mem_Rvalid_I;
  logic [31:0]     Mem_Rdata_I;
  logic            Err_O;

  cgra_lsu_arbiter #(.NB_TILES(N), .TIMEOUT_CYCLES(255)) dut (
    .Clk(Clk), .Reset(Reset),
    .Tile_Req_I(Tile_Req_I), .Tile_Load_I(Tile_Load_I),
    .Tile_Addr_I(Tile_Addr_I), .Tile_Wdata_I(Tile_Wdata_I),
    .Tile_Grant_O(Tile_Grant_O), .Tile_Rvalid_O(Tile_Rvalid_O),
    .Tile_Rdata_O(Tile_Rdata_O), .Stall_O(Stall_O),
    .Mem_Req_O(Mem_Req_O), .Mem_We_O(Mem_We_O),
    .Mem_Addr_O(Mem_Addr_O), .Mem_Wdata_O(Mem_Wdata_O),
    .Mem_Gnt_I(Mem_Gnt_I), .Mem_Rvalid_I(Mem_Rvalid_I), .Mem_Rdata_I(Mem_Rdata_I),
    .Err_O(Err_O)
  );

  always #5 Clk = ~Clk;

  typedef struct { int tile; bit load; logic [31:0] rdata; int unsigned cyc; } rsp_t;
  typedef struct { bit we; logic [31:0] addr; logic [31:0] wdata; int len; } mreq_t;

  rsp_t  exp_rsp[$];
  mreq_t exp_mem[$];

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc   = 0;
  int          pend[N] = '{default: 0};

  // memory responder controls
  int          gnt_delay  = 0;
  int          rv_delay   = 0;
  bit          rv_en      = 1'b1;
  bit          junk_rv    = 1'b0;
  bit          use_fixed  = 1'b0;
  logic [31:0] fixed_rd   = '0;
  bit          rv_pending = 1'b0;
  int          rv_cnt     = 0;
  int          req_cycles = 0;
  logic [31:0] rv_data    = '0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_req"},  32'(Mem_Req_O),     32'h0);
    chk({tag, "_mem_we"},   32'(Mem_We_O),      32'h0);
    chk({tag, "_mem_addr"}, Mem_Addr_O,         32'h0);
    chk({tag, "_mem_wd"},   Mem_Wdata_O,        32'h0);
    chk({tag, "_grant"},    32'(Tile_Grant_O),  32'h0);
    chk({tag, "_rvalid"},   32'(Tile_Rvalid_O), 32'h0);
    chk({tag, "_rdata"},    Tile_Rdata_O,       32'h0);
    chk({tag, "_stall"},    32'(Stall_O),       32'h0);
    chk({tag, "_err"},      32'(Err_O),         32'h0);
  endtask

  // lat: cycles from issue (posedge+2) to the grant sample; 0 = don't care
  task automatic issue(input int t, input bit ld, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int unsigned lat, input int len);
    Tile_Load_I[t]          = ld;
    Tile_Addr_I[32*t +: 32]  = a;
    Tile_Wdata_I[32*t +: 32] = wd;
    exp_mem.push_back('{we: !ld, addr: a, wdata: wd, len: len});
    exp_rsp.push_back('{tile: t, load: ld, rdata: rd, cyc: (lat == 0) ? 0 : cyc + lat});
    pend[t]++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_rsp.size() != 0 && n < budget) begin
      @(posedge Clk); #2;
      n++;
    end
    if (exp_rsp.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_rsp.size());
      exp_rsp.delete();
      exp_mem.delete();
    end
    @(posedge Clk); #2;
  endtask

  // tile model: request held while work is pending, dropped on grant
  initial begin
    Tile_Req_I = '0;
    forever begin
      @(negedge Clk);
      for (int t = 0; t < N; t++) begin
        if (Tile_Grant_O[t] && pend[t] > 0) pend[t]--;
        Tile_Req_I[t] = (pend[t] > 0);
      end
    end
  end

  // memory responder
  initial begin
    Mem_Gnt_I = 1'b0; Mem_Rvalid_I = 1'b0; Mem_Rdata_I = '0;
    forever begin
      @(negedge Clk);
      Mem_Gnt_I = 1'b0; Mem_Rvalid_I = 1'b0; Mem_Rdata_I = '0;
      if (!Reset) begin
        rv_pending = 1'b0;
        req_cycles = 0;
      end else if (rv_pending) begin
        if (rv_cnt == 0) begin
          Mem_Rvalid_I = 1'b1;
          Mem_Rdata_I  = rv_data;
          rv_pending   = 1'b0;
        end else rv_cnt--;
      end else if (Mem_Req_O) begin
        if (req_cycles == gnt_delay) begin
          Mem_Gnt_I  = 1'b1;
          req_cycles = 0;
          if (junk_rv) begin
            Mem_Rvalid_I = 1'b1;
            Mem_Rdata_I  = 32'hBAD0BAD0;
          end
          if (!Mem_We_O && rv_en) begin
            rv_pending = 1'b1;
            rv_cnt     = rv_delay;
            rv_data    = use_fixed ? fixed_rd : mem_fn(Mem_Addr_O);
          end
        end else req_cycles++;
      end
    end
  end

  // memory-side monitor
  initial begin
    int mlen = 0;
    mreq_t e;
    forever begin
      @(negedge Clk); #1;
      if (!Reset) mlen = 0;
      else if (Mem_Req_O) begin
        mlen++;
        if (exp_mem.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL mem_unexpected: request addr %h with none expected", Mem_Addr_O);
        end else begin
          chk("mem_we",    32'(Mem_We_O), 32'(exp_mem[0].we));
          chk("mem_addr",  Mem_Addr_O,    exp_mem[0].addr);
          chk("mem_wdata", Mem_Wdata_O,   exp_mem[0].wdata);
          if (Mem_Gnt_I) begin
            e = exp_mem.pop_front();
            chk("mem_req_len", 32'(mlen), 32'(e.len));
          end
        end
        if (Mem_Gnt_I) mlen = 0;
      end
    end
  end

  // tile-side monitor
  initial begin
    rsp_t e;
    logic [31:0] oh;
    forever begin
      @(posedge Clk); #1;
      if (Reset) begin
        chk("grant_onehot",  32'($countones(Tile_Grant_O) <= 1),  32'h1);
        chk("rvalid_onehot", 32'($countones(Tile_Rvalid_O) <= 1), 32'h1);
        if (|Tile_Grant_O) begin
          if (exp_rsp.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_unexpected: grant %h with none expected", Tile_Grant_O);
          end else begin
            e  = exp_rsp.pop_front();
            oh = 32'h1 << e.tile;
            chk("grant_vec",  32'(Tile_Grant_O),  oh);
            chk("rvalid_vec", 32'(Tile_Rvalid_O), e.load ? oh : 32'h0);
            if (e.load) chk("rdata", Tile_Rdata_O, e.rdata);
            if (e.cyc != 0) chk("grant_cycle", cyc, e.cyc);
            chk("stall_resp", 32'(Stall_O), 32'(Tile_Req_I) & ~oh);
          end
        end else begin
          chk("rvalid_idle", 32'(Tile_Rvalid_O), 32'h0);
          chk("stall",       32'(Stall_O),       32'(Tile_Req_I));
        end
      end
    end
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL global_timeout: still running at %0t, expected finish", $time);
    $fatal(1, "global timeout");
  end

  initial begin
    Reset        = 1'b0;
    Tile_Load_I  = '0;
    Tile_Addr_I  = '0;
    Tile_Wdata_I = '0;
    repeat (3) @(posedge Clk);
    #2;
    chk_reset("por");
    Reset = 1'b1;
    @(posedge Clk); #2;

    // single store, tile 3, grant on first REQ cycle
    gnt_delay = 0;
    issue(3, 1'b0, 32'h100, 32'hA5A5A5A5, 32'h0, 2, 1);
    drain(20);

    // load tile 0, grant delayed 2, rvalid one cycle after
    gnt_delay = 2; rv_delay = 0; use_fixed = 1'b1; fixed_rd = 32'h12345678;
    issue(0, 1'b1, 32'h200, 32'h0, 32'h12345678, 5, 3);
    drain(20);
    repeat (3) @(posedge Clk);
    #2;
    chk("rdata_hold", Tile_Rdata_O, 32'h12345678);

    // minimum-latency load
    gnt_delay = 0; use_fixed = 1'b0;
    issue(9, 1'b1, 32'h340, 32'h0, mem_fn(32'h340), 3, 1);
    drain(20);

    // rvalid coincident with grant must be ignored
    junk_rv = 1'b1; rv_delay = 1;
    issue(6, 1'b1, 32'hABC0, 32'h0, mem_fn(32'hABC0), 4, 1);
    drain(20);
    junk_rv = 1'b0; rv_delay = 0;

    // wrap-around arbitration (last owner 6 -> tile 2 before tile 5) and
    // input changes during REQ must not disturb the transaction
    gnt_delay = 3;
    issue(2, 1'b0, 32'h500, 32'h55AA55AA, 32'h0, 0, 4);
    issue(5, 1'b1, 32'h600, 32'h0, mem_fn(32'h600), 0, 4);
    repeat (2) @(posedge Clk);
    #2;
    Tile_Addr_I[32*2 +: 32]  = 32'hFFF0;
    Tile_Wdata_I[32*2 +: 32] = 32'h0;
    Tile_Load_I[2]           = 1'b1;
    drain(40);
    gnt_delay = 0;

    // reset asserted during WAIT_R
    rv_en = 1'b0;
    issue(4, 1'b1, 32'h700, 32'h0, 32'h0, 0, 1);
    repeat (4) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    chk_reset("mid");
    for (int t = 0; t < N; t++) pend[t] = 0;
    exp_rsp.delete();
    exp_mem.delete();
    rv_en = 1'b1;
    repeat (2) @(posedge Clk);
    #2;
    Reset = 1'b1;
    @(posedge Clk); #2;

    // all tiles requesting: order 0..15 then 0 again
    for (int t = 0; t < N; t++) begin
      issue(t, t[0], 32'h1000 + 32'(t) * 4, 32'(t) * 32'h01010101,
            mem_fn(32'h1000 + 32'(t) * 4), 0, 1);
    end
    issue(0, 1'b0, 32'h1000, 32'h0, 32'h0, 0, 1);
    drain(300);

    // load with no read response
    rv_en = 1'b0;
`ifdef CGRA_LSU_TIMEOUT_EN
    chk("err_before_timeout", 32'(Err_O), 32'h0);
    issue(1, 1'b1, 32'h800, 32'h0, 32'hDEADBEEF, 257, 1);
    drain(400);
    chk("err_after_timeout", 32'(Err_O), 32'h1);
    rv_en = 1'b1;
    issue(7, 1'b0, 32'h900, 32'h77, 32'h0, 2, 1);
    drain(20);
    chk("err_sticky", 32'(Err_O), 32'h1);
`else
    issue(1, 1'b1, 32'h800, 32'h0, 32'h0BADCAFE, 0, 1);
    repeat (300) @(posedge Clk);
    #2;
    chk("wait_no_mem_req", 32'(Mem_Req_O), 32'h0);
    chk("wait_no_grant",   32'(exp_rsp.size()), 32'h1);
    chk("err_tied_low",    32'(Err_O), 32'h0);
    rv_data = 32'h0BADCAFE; rv_cnt = 0; rv_pending = 1'b1;
    drain(20);
    rv_en = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
